// File: rtl/pwm_capture.sv
// Eight-channel PWM period / high-time measurement unit behind a simple rd/wr register bus.
// Latency: dout one cycle after rd; measurements lag the pin by 2-3 cycles through the synchronizer.
// Backpressure: none; the bus is always ready and the capture registers are overwritten on every period.
module pwm_capture #(
  parameter int NCH = 8,
  parameter int CW  = 32
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           rd,
  input  logic           wr,
  input  logic [31:0]    din,
  input  logic [6:0]     adrs,
  output logic [31:0]    dout,
  input  logic [NCH-1:0] pwmi,
  output logic           irq
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ARM  = 2'd1,
    MEAS = 2'd2
  } state_t;

  localparam logic [CW-1:0] CMAX    = {CW{1'b1}};
  localparam logic [CW-1:0] CMAX_M1 = {{(CW-1){1'b1}}, 1'b0};
  localparam logic [CW-1:0] ONE     = {{(CW-1){1'b0}}, 1'b1};
  localparam logic [6:0]    ADR_STATUS = 7'h60;
  localparam logic [6:0]    ADR_OVF    = 7'h64;

  logic [NCH-1:0] sync1, sync2, sync_d, re;
  logic [NCH-1:0] en, ien, valid, ovf;
  logic [CW-1:0]  period [NCH];
  logic [CW-1:0]  high   [NCH];
  logic           sts_we, ovf_we;
  logic [31:0]    rdata;
  logic           unused_din;

  assign sts_we     = wr && (adrs == ADR_STATUS);
  assign ovf_we     = wr && (adrs == ADR_OVF);
  assign re         = sync2 & ~sync_d;
  assign irq        = |(valid & ien);
  // Only the low bits of din carry meaning; the rest are reduced away here.
  assign unused_din = ^din;

  // Two-flop synchronizer plus one delay stage for rising-edge detection.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1  <= '0;
      sync2  <= '0;
      sync_d <= '0;
    end else begin
      sync1  <= pwmi;
      sync2  <= sync1;
      sync_d <= sync2;
    end
  end

  for (genvar n = 0; n < NCH; n++) begin : g_ch
    localparam logic [6:0] BASE = 7'(n * 12);

    state_t        state, state_nxt;
    logic          cnt_clr, cnt_start, cnt_run, cap, ovf_set, ctrl_we;
    logic [CW-1:0] cnt, hcnt;
    logic [CW-1:0] period_q, high_q;
    logic          en_q, ien_q, valid_q, ovf_q;

    assign ctrl_we   = wr && (adrs == BASE);
    assign ovf_set   = cnt_run && (cnt == CMAX_M1);
    assign en[n]     = en_q;
    assign ien[n]    = ien_q;
    assign valid[n]  = valid_q;
    assign ovf[n]    = ovf_q;
    assign period[n] = period_q;
    assign high[n]   = high_q;

    // Channel FSM state register.
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= IDLE;
      else      state <= state_nxt;
    end

    // Next state: disabling always returns to IDLE; the first edge after arming only starts counting.
    always_comb begin
      state_nxt = state;
      case (state)
        IDLE:    state_nxt = ARM;
        ARM:     if (re[n]) state_nxt = MEAS;
        MEAS:    state_nxt = MEAS;
        default: state_nxt = IDLE;
      endcase
      if (!en_q) state_nxt = IDLE;
    end

    // Counter controls decoded from state; a disabled channel holds its counters at zero.
    always_comb begin
      cnt_clr   = 1'b0;
      cnt_start = 1'b0;
      cnt_run   = 1'b0;
      cap       = 1'b0;
      case (state)
        IDLE:    cnt_clr = 1'b1;
        ARM:     cnt_start = re[n];
        MEAS:    begin
                   cap     = re[n];
                   cnt_run = ~re[n];
                 end
        default: cnt_clr = 1'b1;
      endcase
      if (!en_q) begin
        cnt_clr   = 1'b1;
        cnt_start = 1'b0;
        cnt_run   = 1'b0;
        cap       = 1'b0;
      end
    end

    // Period and high-time counters, both saturating; the edge cycle itself counts as 1.
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        cnt  <= '0;
        hcnt <= '0;
      end else if (cnt_clr) begin
        cnt  <= '0;
        hcnt <= '0;
      end else if (cnt_start || cap) begin
        cnt  <= ONE;
        hcnt <= ONE;
      end else if (cnt_run) begin
        if (cnt != CMAX) cnt <= cnt + ONE;
        if (sync2[n] && (hcnt != CMAX)) hcnt <= hcnt + ONE;
      end
    end

    // Result registers keep their last capture across disable.
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        period_q <= '0;
        high_q   <= '0;
      end else if (cap) begin
        period_q <= cnt;
        high_q   <= hcnt;
      end
    end

    // CTRL and the sticky flags; a hardware set beats a same-cycle W1C clear.
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        en_q    <= 1'b0;
        ien_q   <= 1'b0;
        valid_q <= 1'b0;
        ovf_q   <= 1'b0;
      end else begin
        if (ctrl_we) begin
          en_q  <= din[0];
          ien_q <= din[1];
        end
        valid_q <= cap     | (valid_q & ~(sts_we & din[n]));
        ovf_q   <= ovf_set | (ovf_q   & ~(ovf_we & din[n]));
      end
    end
  end

  // Read decode; anything not matching an exact register address reads as zero.
  always_comb begin
    rdata = '0;
    for (int n = 0; n < NCH; n++) begin
      if (adrs == 7'(n * 12))     rdata = {30'd0, ien[n], en[n]};
      if (adrs == 7'(n * 12 + 4)) rdata = 32'(period[n]);
      if (adrs == 7'(n * 12 + 8)) rdata = 32'(high[n]);
    end
    if (adrs == ADR_STATUS) rdata = 32'(valid);
    if (adrs == ADR_OVF)    rdata = 32'(ovf);
  end

  // Registered read port; idle cycles return zero.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)    dout <= '0;
    else if (rd) dout <= rdata;
    else         dout <= '0;
  end

endmodule

// File: tb/tb_pwm_capture.sv
// Directed bench for pwm_capture: bus reads push expectations, a monitor checks dout.
// Latency: expects dout exactly one cycle after each rd.
// Backpressure: none; PWM stimulus comes from a per-channel generator or manual pin drive.
module tb_pwm_capture;
  localparam int NCH = 8;
  localparam int CW  = 8;

  logic           clk = 1'b0;
  logic           rst, rd, wr;
  logic [31:0]    din;
  logic [6:0]     adrs;
  logic [31:0]    dout;
  logic [NCH-1:0] pwmi;
  logic           irq;

  logic [NCH-1:0] gen_out = '0;
  logic [NCH-1:0] ch_on   = '0;
  logic [NCH-1:0] man     = '0;
  int             gen_per [NCH];
  int             gen_hi  [NCH];
  int             phase   [NCH];

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic [6:0]  adr;
    logic [31:0] val;
  } rd_exp_t;
  rd_exp_t exp_q[$];

  assign pwmi = (gen_out & ch_on) | (man & ~ch_on);

  always #5 clk = ~clk;

  pwm_capture #(.NCH(NCH), .CW(CW)) dut (
    .clk  (clk),
    .rst  (rst),
    .rd   (rd),
    .wr   (wr),
    .din  (din),
    .adrs (adrs),
    .dout (dout),
    .pwmi (pwmi),
    .irq  (irq)
  );

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic bus_wr(input logic [6:0] a, input logic [31:0] d);
    adrs = a; din = d; wr = 1'b1;
    tick(1);
    wr = 1'b0;
  endtask

  task automatic bus_rd(input logic [6:0] a, input logic [31:0] e);
    exp_q.push_back('{adr: a, val: e});
    adrs = a; rd = 1'b1;
    tick(1);
    rd = 1'b0;
  endtask

  task automatic bus_rdwr(input logic [6:0] a, input logic [31:0] d, input logic [31:0] e);
    exp_q.push_back('{adr: a, val: e});
    adrs = a; din = d; rd = 1'b1; wr = 1'b1;
    tick(1);
    rd = 1'b0; wr = 1'b0;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic wait_irq(input string nm, input int limit);
    int k = 0;
    while (irq !== 1'b1 && k < limit) begin
      tick(1);
      k++;
    end
    n_cmp++;
    if (irq !== 1'b1) begin
      n_bad++;
      $display("FAIL %s: irq=%b after %0d cycles, expected 1", nm, irq, limit);
    end
  endtask

  // PWM generator: one sample per clock, phase restarts whenever a channel is switched off.
  initial begin
    for (int n = 0; n < NCH; n++) phase[n] = 0;
    forever begin
      @(posedge clk);
      #2;
      for (int n = 0; n < NCH; n++) begin
        if (!ch_on[n]) begin
          phase[n]   = 0;
          gen_out[n] = 1'b0;
        end else begin
          gen_out[n] = (phase[n] < gen_hi[n]);
          phase[n]   = (phase[n] + 1 == gen_per[n]) ? 0 : phase[n] + 1;
        end
      end
    end
  end

  // Monitor: a read seen at an edge is checked against the queue head at the following negedge.
  initial begin : mon
    logic    rd_s;
    rd_exp_t x;
    forever begin
      @(posedge clk);
      rd_s = rd;
      @(negedge clk);
      if (rd_s === 1'b1) begin
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_bad++;
          $display("FAIL unexpected_read: dout=%0h with no expectation queued", dout);
        end else begin
          x = exp_q.pop_front();
          if (dout !== x.val) begin
            n_bad++;
            $display("FAIL rd_%02h: dout=%0h expected %0h", x.adr, dout, x.val);
          end
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    for (int n = 0; n < NCH; n++) begin
      gen_per[n] = 20;
      gen_hi[n]  = 2;
    end
    rst = 1'b0; rd = 1'b0; wr = 1'b0; din = '0; adrs = '0;
    tick(3);
    chk("rst_dout", dout, 32'h0);
    chk("rst_irq", {31'd0, irq}, 32'h0);
    rst = 1'b1;
    tick(1);
    bus_rd(7'h00, 32'h0);
    bus_rd(7'h04, 32'h0);
    bus_rd(7'h08, 32'h0);
    bus_rd(7'h54, 32'h0);
    bus_rd(7'h60, 32'h0);
    bus_rd(7'h64, 32'h0);

    // ch0: period 20, high 2
    gen_per[0] = 20; gen_hi[0] = 2; ch_on[0] = 1'b1;
    bus_wr(7'h00, 32'h1);
    tick(15);
    bus_rd(7'h60, 32'h0);
    tick(60);
    bus_rd(7'h60, 32'h1);
    bus_rd(7'h04, 32'd20);
    bus_rd(7'h08, 32'd2);
    bus_rd(7'h00, 32'h1);
    bus_rd(7'h64, 32'h0);
    bus_wr(7'h00, 32'h0);
    ch_on[0] = 1'b0;
    bus_wr(7'h60, 32'hFF);
    bus_rd(7'h60, 32'h0);
    bus_rd(7'h04, 32'd20);

    // ch2: period 20, high 4, interrupt enabled
    gen_per[2] = 20; gen_hi[2] = 4; ch_on[2] = 1'b1;
    bus_wr(7'h18, 32'h3);
    chk("irq_before_capture", {31'd0, irq}, 32'h0);
    wait_irq("irq_first_capture", 100);
    bus_rd(7'h60, 32'h4);
    bus_rd(7'h1C, 32'd20);
    bus_rd(7'h20, 32'd4);
    bus_rd(7'h18, 32'h3);
    bus_wr(7'h60, 32'h4);
    chk("irq_after_w1c", {31'd0, irq}, 32'h0);
    bus_rd(7'h60, 32'h0);
    wait_irq("irq_next_capture", 30);
    bus_wr(7'h18, 32'h0);
    ch_on[2] = 1'b0;
    bus_wr(7'h60, 32'hFF);
    chk("irq_ch2_off", {31'd0, irq}, 32'h0);

    // ch7: one edge then held low -> saturation at 255
    bus_wr(7'h54, 32'h1);
    tick(5);
    man[7] = 1'b1;
    tick(3);
    man[7] = 1'b0;
    tick(100);
    bus_rd(7'h64, 32'h0);
    tick(160);
    bus_rd(7'h64, 32'h80);
    bus_rd(7'h60, 32'h0);
    man[7] = 1'b1;
    tick(3);
    man[7] = 1'b0;
    tick(6);
    bus_rd(7'h58, 32'd255);
    bus_rd(7'h5C, 32'd3);
    bus_rd(7'h60, 32'h80);
    bus_wr(7'h64, 32'h80);
    bus_rd(7'h64, 32'h0);
    bus_wr(7'h54, 32'h0);
    bus_wr(7'h60, 32'hFF);

    // ch1: W1C of STATUS lands on the same edge as a capture
    bus_wr(7'h0C, 32'h1);
    tick(3);
    man[1] = 1'b1;
    tick(2);
    man[1] = 1'b0;
    tick(28);
    man[1] = 1'b1;
    tick(2);
    bus_wr(7'h60, 32'h2);
    bus_rd(7'h60, 32'h2);
    bus_rd(7'h10, 32'd30);
    bus_rd(7'h14, 32'd2);
    chk("irq_ch1_no_ien", {31'd0, irq}, 32'h0);
    man[1] = 1'b0;

    // reset mid-measurement on ch0
    ch_on[0] = 1'b1;
    bus_wr(7'h00, 32'h1);
    tick(30);
    rst = 1'b0;
    tick(2);
    chk("midrst_dout", dout, 32'h0);
    chk("midrst_irq", {31'd0, irq}, 32'h0);
    rst = 1'b1;
    tick(1);
    bus_rd(7'h00, 32'h0);
    bus_rd(7'h04, 32'h0);
    bus_rd(7'h08, 32'h0);
    bus_rd(7'h0C, 32'h0);
    bus_rd(7'h10, 32'h0);
    bus_rd(7'h60, 32'h0);
    bus_rd(7'h64, 32'h0);
    bus_wr(7'h00, 32'h1);
    tick(5);
    bus_rd(7'h60, 32'h0);
    tick(60);
    bus_rd(7'h60, 32'h1);
    bus_rd(7'h04, 32'd20);
    bus_rd(7'h08, 32'd2);

    // simultaneous rd/wr, unmapped and read-only addresses
    bus_rdwr(7'h0C, 32'h1, 32'h0);
    bus_rd(7'h0C, 32'h1);
    bus_rd(7'h70, 32'h0);
    bus_rd(7'h62, 32'h0);
    bus_wr(7'h04, 32'h55);
    bus_rd(7'h04, 32'd20);

    tick(3);
    chk("queue_drained", exp_q.size(), 32'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
